// File: rtl/uart_tx_framed.sv
// UART transmitter: configurable data width, parity and stop bits, with a one-entry holding
// register for back-to-back frames. Define UART_TX_FRAMED_CTS_EN to add cts_n flow control.
module uart_tx_framed #(
  parameter int unsigned SYSTEM_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 srst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_bit,
  output logic                 tx_busy,
  output logic                 tx_done
`ifdef UART_TX_FRAMED_CTS_EN
  ,
  input  logic                 cts_n
`endif
);

  localparam int unsigned DIVISOR = SYSTEM_FREQ / BAUD_RATE;
  localparam int unsigned CntW    = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam int unsigned BitW    = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);

  localparam logic [CntW-1:0] BaudLast = CntW'(DIVISOR - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic            StopLast = (STOP_BITS == 2);
  localparam logic            ParOdd   = (PARITY == 2);

  if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_framed: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic                 line_q, busy_q, done_q;

  logic line, done, load, accept, baud_tick, clear_to_send;

`ifdef UART_TX_FRAMED_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clock) begin
    if (srst) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= {cts_sync_q[0], cts_n};
    end
  end

  assign clear_to_send = ~cts_sync_q[1];
`else
  assign clear_to_send = 1'b1;
`endif

  assign accept    = tx_valid & ~hold_full_q;
  assign baud_tick = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    line    = 1'b1;
    done    = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        load   = hold_full_q & clear_to_send;
      end
      StStart: begin
        line = 1'b0;
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        line = shift_q[0];
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DataLast) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d = StParity;
            end else begin
              state_d = StStop;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        line = par_q;
        if (baud_tick) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (baud_tick) begin
          baud_d = '0;
          if (stop_q == StopLast) begin
            done = 1'b1;
            load = hold_full_q & clear_to_send;
            if (!load) begin
              state_d = StIdle;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Shifter load overrides the per-state next values; parity is frozen with the word.
    if (load) begin
      state_d = StStart;
      baud_d  = '0;
      shift_d = hold_q;
      par_d   = (^hold_q) ^ ParOdd;
    end
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      if (accept) begin
        hold_q <= tx_data;
      end
      // accept needs an empty holder and load a full one, so they never collide.
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q <= 1'b1;
      end
      line_q <= line;
      busy_q <= (state_q != StIdle);
      done_q <= done;
    end
  end

  assign tx_ready = ~hold_full_q;
  assign tx_bit   = line_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: 8N1, 8E1, 8O1 and 7N2 instances at DIVISOR=10, with the
// cts_n scenario included when UART_TX_FRAMED_CTS_EN is defined.
module tb_uart_tx_framed;

  localparam int Div = 10;

  logic       clock = 1'b0;
  logic       srst  = 1'b1;
  logic [7:0] data8 = '0;
  logic [6:0] data7 = '0;
  logic [3:0] valid = '0;
  logic [3:0] rdy_w, bit_w, busy_w, done_w;
  logic [1:0] sel   = '0;
`ifdef UART_TX_FRAMED_CTS_EN
  logic       cts_n = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [255:0] got_b, got_bu, got_dn, got_rd;
  logic [255:0] exp_b, exp_bu, exp_dn, exp_rd;

  always #5 clock = ~clock;

  uart_tx_framed #(.SYSTEM_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1)) u_8n1 (
    .clock(clock), .srst(srst), .tx_data(data8), .tx_valid(valid[0]), .tx_ready(rdy_w[0]),
    .tx_bit(bit_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
`ifdef UART_TX_FRAMED_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  uart_tx_framed #(.SYSTEM_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1)) u_8e1 (
    .clock(clock), .srst(srst), .tx_data(data8), .tx_valid(valid[1]), .tx_ready(rdy_w[1]),
    .tx_bit(bit_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
`ifdef UART_TX_FRAMED_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  uart_tx_framed #(.SYSTEM_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1)) u_8o1 (
    .clock(clock), .srst(srst), .tx_data(data8), .tx_valid(valid[2]), .tx_ready(rdy_w[2]),
    .tx_bit(bit_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
`ifdef UART_TX_FRAMED_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  uart_tx_framed #(.SYSTEM_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2)) u_7n2 (
    .clock(clock), .srst(srst), .tx_data(data7), .tx_valid(valid[3]), .tx_ready(rdy_w[3]),
    .tx_bit(bit_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
`ifdef UART_TX_FRAMED_CTS_EN
    , .cts_n(cts_n)
`endif
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input int idx, input logic [8:0] d, input int nb,
                                     input int par);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= nb) return d[idx-1];
    if (par != 0 && idx == nb + 1) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      return (par == 2) ? ~p : p;
    end
    return 1'b1;
  endfunction

  // Interval k of a capture is the clock period following the k-th edge after the accept edge.
  task automatic capture(input int n, input int drop_at);
    got_b = '0; got_bu = '0; got_dn = '0; got_rd = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      got_b[k]  = bit_w[sel];
      got_bu[k] = busy_w[sel];
      got_dn[k] = done_w[sel];
      got_rd[k] = rdy_w[sel];
      if (k == drop_at) valid = '0;
    end
  endtask

  task automatic exp_init(input int n, input logic rdy);
    logic [255:0] m;
    m = (256'd1 << n) - 256'd1;
    exp_b  = m;
    exp_bu = '0;
    exp_dn = '0;
    exp_rd = rdy ? m : '0;
  endtask

  task automatic exp_frame(input int n, input int off, input logic [8:0] d, input int nb,
                           input int par, input int sb);
    int len;
    len = Div * (1 + nb + ((par != 0) ? 1 : 0) + sb);
    for (int c = 0; c < len; c++) begin
      if (off + c >= 0 && off + c < n) begin
        exp_b[off+c]  = frame_bit(c / Div, d, nb, par);
        exp_bu[off+c] = 1'b1;
        if (c == len - 1) exp_dn[off+c] = 1'b1;
      end
    end
  endtask

  task automatic exp_ready(input int lo, input int hi, input logic v);
    for (int k = lo; k <= hi; k++) exp_rd[k] = v;
  endtask

  task automatic check_window(input string tag);
    check_eq({tag, ".bit"},   got_b,  exp_b);
    check_eq({tag, ".busy"},  got_bu, exp_bu);
    check_eq({tag, ".done"},  got_dn, exp_dn);
    check_eq({tag, ".ready"}, got_rd, exp_rd);
  endtask

  // Returns just after the accept edge.
  task automatic send(input int s, input logic [8:0] d, input bit keep);
    int w;
    w     = 0;
    sel   = 2'(s);
    data8 = d[7:0];
    data7 = d[6:0];
    valid[s] = 1'b1;
    while (!rdy_w[s] && w < 300) begin
      @(posedge clock);
      #1;
      w++;
    end
    check_eq("send.ready", 256'(rdy_w[s]), 256'd1);
    @(posedge clock);
    #1;
    if (!keep) valid[s] = 1'b0;
  endtask

  initial begin
    logic [9:0] mid;
    int         cnt;

    // A handshake held during reset must be dropped.
    valid[0] = 1'b1;
    data8    = 8'h5A;
    repeat (4) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 4; s++) begin
      check_eq("rst.bit",   256'(bit_w[s]),  256'd1);
      check_eq("rst.ready", 256'(rdy_w[s]),  256'd1);
      check_eq("rst.busy",  256'(busy_w[s]), 256'd0);
      check_eq("rst.done",  256'(done_w[s]), 256'd0);
    end
    srst  = 1'b0;
    valid = '0;
    sel   = 2'd0;
    capture(20, -1);
    exp_init(20, 1'b1);
    check_window("rst_discard");

    // 8N1, 8'hA5
    send(0, 9'h0A5, 1'b0);
    capture(103, -1);
    exp_init(103, 1'b1);
    exp_frame(103, 2, 9'h0A5, 8, 0, 1);
    exp_ready(0, 0, 1'b0);
    check_window("8n1");
    for (int i = 0; i < 10; i++) mid[i] = got_b[7+10*i];
    check_eq("8n1.midbits", 256'(mid), 256'h34A);

    // 8E1 / 8O1: A5 has four ones
    send(1, 9'h0A5, 1'b0);
    capture(113, -1);
    exp_init(113, 1'b1);
    exp_frame(113, 2, 9'h0A5, 8, 1, 1);
    exp_ready(0, 0, 1'b0);
    check_window("8e1");
    check_eq("8e1.parity", 256'(got_b[97]), 256'd0);

    send(2, 9'h0A5, 1'b0);
    capture(113, -1);
    exp_init(113, 1'b1);
    exp_frame(113, 2, 9'h0A5, 8, 2, 1);
    exp_ready(0, 0, 1'b0);
    check_window("8o1");
    check_eq("8o1.parity", 256'(got_b[97]), 256'd1);

    // 7N2, 7'h55
    send(3, 9'h055, 1'b0);
    capture(103, -1);
    exp_init(103, 1'b1);
    exp_frame(103, 2, 9'h055, 7, 0, 2);
    exp_ready(0, 0, 1'b0);
    check_window("7n2");
    check_eq("7n2.stop", 256'(got_b[101:82]), 256'hFFFFF);
    cnt = 0;
    for (int k = 0; k < 103; k++) cnt += int'(got_bu[k]);
    check_eq("7n2.len", 256'(cnt), 256'd100);

    // Back-to-back: 8'h01 then 8'h80 with tx_valid held
    send(0, 9'h001, 1'b1);
    data8 = 8'h80;
    capture(203, 2);
    exp_init(203, 1'b1);
    exp_frame(203, 2, 9'h001, 8, 0, 1);
    exp_frame(203, 102, 9'h080, 8, 0, 1);
    exp_ready(0, 0, 1'b0);
    exp_ready(2, 100, 1'b0);
    check_window("b2b");
    check_eq("b2b.gap", 256'({got_dn[101], got_b[102]}), 256'b10);

    // Reset mid-frame, then a clean frame
    send(0, 9'h000, 1'b0);
    repeat (37) @(negedge clock);
    check_eq("rst_mid.pre", 256'(bit_w[0]), 256'd0);
    srst = 1'b1;
    @(negedge clock);
    check_eq("rst_mid.bit",   256'(bit_w[0]),  256'd1);
    check_eq("rst_mid.busy",  256'(busy_w[0]), 256'd0);
    check_eq("rst_mid.ready", 256'(rdy_w[0]),  256'd1);
    check_eq("rst_mid.done",  256'(done_w[0]), 256'd0);
    srst = 1'b0;
    capture(30, -1);
    exp_init(30, 1'b1);
    check_window("rst_mid.after");
    send(0, 9'h0A5, 1'b0);
    capture(103, -1);
    exp_init(103, 1'b1);
    exp_frame(103, 2, 9'h0A5, 8, 0, 1);
    exp_ready(0, 0, 1'b0);
    check_window("rst_mid.resend");

`ifdef UART_TX_FRAMED_CTS_EN
    // Held off by cts_n, start 2 sync + 1 FSM + 1 output cycles after the drop
    cts_n = 1'b1;
    repeat (4) @(negedge clock);
    send(0, 9'h03C, 1'b0);
    capture(20, -1);
    exp_init(20, 1'b0);
    check_window("cts.hold");
    cts_n = 1'b0;
    capture(40, -1);
    exp_init(40, 1'b1);
    exp_frame(40, 3, 9'h03C, 8, 0, 1);
    exp_ready(0, 1, 1'b0);
    check_window("cts.start");
    cts_n = 1'b1;
    capture(65, -1);
    exp_init(65, 1'b1);
    exp_frame(65, -37, 9'h03C, 8, 0, 1);
    check_window("cts.finish");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
